// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED blink scheduler.
//   state_e    : scheduler states
//   MAX_REQ    : widest requester vector rr_pick can handle
//   tick_width : width of the tick down-counter for the given durations
//   rr_pick    : round-robin pick, returns a one-hot vector (zero if no request)
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam int MAX_REQ = 32;

    function automatic int tick_width(input int on_t, input int off_t, input int gap_t);
        int m;
        m = on_t;
        if (off_t > m) m = off_t;
        if (gap_t > m) m = gap_t;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    // Scan n requesters starting at ptr, wrapping n-1 -> 0; first set bit wins.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input int ptr, input int n);
        logic [MAX_REQ-1:0] g;
        logic               found;
        int                 idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n && !found) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[4:0]]) begin
                    g[idx[4:0]] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/led_tick_timer.sv
// Loadable down-counter used to time each scheduler state.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : duration-1 of the state being entered
//   expired   : count has reached zero
//   count     : current count value
module led_tick_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);
    assign count   = cnt_q;

endmodule

// File: rtl/led_blink_sched.sv
// Round-robin scheduler sharing one blinking LED between NUM_REQ requesters.
// Each grant runs BLINKS on/off cycles followed by a dark gap, then releases.
//   clk, rst : clock, async active-high reset
//   enable   : low blocks new grants and aborts a running burst
//   req      : level request per requester (sampled only in IDLE)
//   grant    : one-hot LED owner, zero when idle
//   done     : one-cycle pulse on the owner's bit in the last GAP cycle
//   busy     : high whenever not IDLE
//   led      : LED drive, 1 = lit
// Optional feature macro: LED_PREEMPT_EN (req[0] preempts at the end of an OFF phase
// and always wins arbitration).
//
// state | meaning
// IDLE  | no owner; arbitrate when enabled and any req is set
// ON    | LED lit for ON_TICKS cycles
// OFF   | LED dark for OFF_TICKS cycles; next blink, gap, or preempt abort
// GAP   | LED dark for GAP_TICKS cycles; done pulses in the last one
module led_blink_sched
    import led_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BLINKS    = 3,
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 4,
    parameter int GAP_TICKS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               led
);

    localparam int TW = tick_width(ON_TICKS, OFF_TICKS, GAP_TICKS);
    localparam int PW = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ);
    localparam int BW = (BLINKS <= 2) ? 1 : $clog2(BLINKS);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;

    logic               tmr_load;
    logic [TW-1:0]      tmr_load_val;
    logic               tmr_expired;
    logic [TW-1:0]      tmr_count;

    logic [MAX_REQ-1:0] pick_full;
    logic [NUM_REQ-1:0] pick;
    logic [PW-1:0]      win_idx;
    logic               preempt;

    led_tick_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expired  (tmr_expired),
        .count    (tmr_count)
    );

    always_comb begin
        pick_full = rr_pick(MAX_REQ'(req), 32'(rr_ptr_q), NUM_REQ);
        pick      = pick_full[NUM_REQ-1:0];
        preempt   = 1'b0;
`ifdef LED_PREEMPT_EN
        if (req[0]) pick = NUM_REQ'(1);
        preempt = req[0] && !grant_q[0];
`endif
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) win_idx = PW'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        blink_cnt_d = blink_cnt_q;
        rr_ptr_d    = rr_ptr_q;

        case (state_q)
            IDLE: begin
                if (enable && (|req)) begin
                    state_d     = ON;
                    grant_d     = pick;
                    blink_cnt_d = '0;
                    rr_ptr_d    = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PW'(1);
                end
            end
            ON: begin
                if (tmr_expired) state_d = OFF;
            end
            OFF: begin
                if (tmr_expired) begin
                    if (preempt) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end else if (32'(blink_cnt_q) == BLINKS - 1) begin
                        state_d = GAP;
                    end else begin
                        state_d     = ON;
                        blink_cnt_d = blink_cnt_q + BW'(1);
                    end
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (!enable && state_q != IDLE) begin
            state_d = IDLE;
            grant_d = '0;
        end
    end

    // Timer reloads on every state change with the new state's duration-1.
    always_comb begin
        tmr_load     = (state_d != state_q);
        tmr_load_val = '0;
        case (state_d)
            ON:      tmr_load_val = TW'(ON_TICKS - 1);
            OFF:     tmr_load_val = TW'(OFF_TICKS - 1);
            GAP:     tmr_load_val = TW'(GAP_TICKS - 1);
            default: tmr_load_val = '0;
        endcase
    end

    // done is registered, so it is raised when the next cycle will be the
    // final GAP cycle (timer about to read zero while staying in GAP).
    always_comb begin
        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
        done_d = '0;
        if (state_d == GAP &&
            ((tmr_load && tmr_load_val == '0) || (!tmr_load && tmr_count == TW'(1))))
            done_d = grant_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            blink_cnt_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            blink_cnt_q <= blink_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign led   = led_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_blink_sched.sv
// Scoreboard bench for led_blink_sched with default parameters.
module tb_led_blink_sched;

    localparam int NR   = 4;
    localparam int BL   = 3;
    localparam int ONT  = 4;
    localparam int OFFT = 4;
    localparam int GAPT = 8;
    localparam int FULL = BL * (ONT + OFFT) + GAPT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] grant, done;
    logic          busy, led;

    led_blink_sched #(
        .NUM_REQ(NR), .BLINKS(BL), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GAPT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req),
        .grant(grant), .done(done), .busy(busy), .led(led)
    );

    always #2 clk = ~clk;

    typedef struct {
        logic [NR-1:0] g;
        int            len;
        int            done_pos;
        int            gap;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    bit            in_burst = 0;
    int            pos = 0;
    int            bursts = 0;
    int            idle_cnt = 0;
    int            idle_bad = 0;
    int            burst_bad = 0;
    int            done_pos = 0;
    int            gap_seen = 0;
    logic [NR-1:0] cur_g = '0;

    task automatic close_burst();
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_burst", int'(cur_g), 0);
        end else begin
            e = sb.pop_front();
            check("grant", int'(cur_g), int'(e.g));
            check("burst_len", pos, e.len);
            check("done_pos", done_pos, e.done_pos);
            check("led_busy_pattern", burst_bad, 0);
            if (e.gap >= 0) check("idle_gap", gap_seen, e.gap);
        end
    endtask

    always @(negedge clk) begin
        logic exp_led;
        if (grant != '0) begin
            if (!in_burst) begin
                in_burst  = 1;
                cur_g     = grant;
                pos       = 0;
                burst_bad = 0;
                done_pos  = 0;
                gap_seen  = idle_cnt;
                bursts++;
            end
            pos++;
            exp_led = (pos <= BL * (ONT + OFFT)) && (((pos - 1) % (ONT + OFFT)) < ONT);
            if (led !== exp_led) burst_bad++;
            if (busy !== 1'b1) burst_bad++;
            if (grant !== cur_g) burst_bad++;
            if (done != '0) begin
                if (done === cur_g && done_pos == 0) done_pos = pos;
                else burst_bad++;
            end
        end else begin
            if (in_burst) begin
                close_burst();
                in_burst = 0;
                idle_cnt = 0;
            end
            idle_cnt++;
            if (led !== 1'b0 || busy !== 1'b0 || done !== '0) idle_bad++;
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pos(input int nb, input int p, input string tag);
        bit ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (bursts >= nb && in_burst && pos >= p) ok = 1;
        end
        if (!ok) check(tag, 0, 1);
    endtask

    task automatic wait_drain(input string tag);
        bit ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !in_burst) ok = 1;
        end
        if (!ok) check(tag, sb.size(), 0);
    endtask

    task automatic push(input logic [NR-1:0] g, input int len, input bit full, input int gap);
        exp_t e;
        e.g        = g;
        e.len      = len;
        e.done_pos = full ? len : 0;
        e.gap      = gap;
        sb.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nb;

        // 1: reset, then idle with no requests
        #1;
        check("rst_led", int'(led), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 0);
        cyc(2);
        rst = 1'b0;
        cyc(50);
        check("t1_no_burst", bursts, 0);
        check("t1_quiet", idle_bad, 0);

        // 2: single-cycle request from requester 1
        push(4'b0010, FULL, 1, -1);
        req = 4'b0010;
        cyc(1);
        req = '0;
        check("t2_grant_next", int'(grant), 4'b0010);
        check("t2_led_next", int'(led), 1);
        wait_drain("t2_timeout");

        // 3: all requesting from reset state -> strict rotation
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        push(4'b0001, FULL, 1, -1);
        push(4'b0010, FULL, 1, 1);
        push(4'b0100, FULL, 1, 1);
        push(4'b1000, FULL, 1, 1);
        push(4'b0001, FULL, 1, 1);
        nb = bursts;
        req = 4'b1111;
        wait_pos(nb + 5, 1, "t3_timeout");
        req = '0;
        wait_drain("t3_drain");

        // 4: enable drop in the second ON phase, next requester wins after
        nb = bursts;
        push(4'b0010, 10, 0, -1);
        push(4'b0100, FULL, 1, -1);
        req = 4'b1111;
        wait_pos(nb + 1, 10, "t4_timeout");
        enable = 1'b0;
        cyc(1);
        check("t4_led_off", int'(led), 0);
        check("t4_grant_off", int'(grant), 0);
        check("t4_busy_off", int'(busy), 0);
        cyc(2);
        enable = 1'b1;
        wait_pos(nb + 2, 1, "t4_regrant");
        req = '0;
        wait_drain("t4_drain");

        // 5: async reset in the middle of an OFF phase
        nb = bursts;
        push(4'b0100, 6, 0, -1);
        push(4'b0001, FULL, 1, -1);
        req = 4'b0100;
        cyc(1);
        req = '0;
        wait_pos(nb + 1, 6, "t5_timeout");
        rst = 1'b1;
        #1;
        check("t5_async_led", int'(led), 0);
        check("t5_async_grant", int'(grant), 0);
        check("t5_async_busy", int'(busy), 0);
        check("t5_async_done", int'(done), 0);
        cyc(2);
        rst = 1'b0;
        req = 4'b1111;
        wait_pos(nb + 2, 1, "t5_regrant");
        req = '0;
        wait_drain("t5_drain");

        // 6: req[0] raised while requester 2 is in blink 1 ON
        nb = bursts;
`ifdef LED_PREEMPT_EN
        push(4'b0100, 2 * (ONT + OFFT), 0, -1);
`else
        push(4'b0100, FULL, 1, -1);
`endif
        push(4'b0001, FULL, 1, 1);
        req = 4'b0100;
        wait_pos(nb + 1, ONT + OFFT + 2, "t6_timeout");
        req = 4'b0001;
        wait_pos(nb + 2, 1, "t6_regrant");
        req = '0;
        wait_drain("t6_drain");

        cyc(5);
        check("sb_empty", sb.size(), 0);
        check("idle_quiet", idle_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
